// File: rtl/vending_machine_gen.sv
// vending_machine_gen
// Stock-aware vending transaction engine. Accepts coins through a
// valid/ready port, checks a keypad selection against the catalogue price
// and the slot stock, emits a one-cycle vend pulse and then returns change
// one coin per cycle, largest coin first.
//
// Ports:
//   clock, reset               single rising-edge clock, synchronous active-high reset
//   coin_valid/coin_code       offered coin (0 nickel, 1 dime, 2 quarter, 3 dollar)
//   coin_ready                 coin taken on a cycle where coin_valid & coin_ready
//   sel_valid/selection        selection strobe and item index
//   cancel, restock            refund request, reload every slot to INIT_STOCK
//   credit                     current credit in cents
//   item_valid/item_dispensed  vend pulse and the item vended
//   coin_out_valid/_code       one change coin this cycle
//   change_*                   per-denomination coins returned this/last transaction
//   change_done                high together with the final change coin
//   err_funds/err_sold_out     one-cycle rejection pulses
//   sold_out                   bit i set when slot i is empty
//   busy                       transaction engine is not idle
//   state_dbg                  raw FSM state for observation
//
// Handshake: a coin is consumed on every rising edge where coin_valid and
// coin_ready are both high; coin_ready depends only on registered state, so
// the front end may hold coin_valid until it sees the acceptance.
module vending_machine_gen #(
  parameter int N_ITEMS    = 8,
  parameter int SEL_W      = 3,
  parameter int CREDIT_W   = 9,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int PRICE_BASE = 25,
  parameter int PRICE_STEP = 15,
  parameter int CNT_W      = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  output logic                coin_ready,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    selection,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic                item_valid,
  output logic [SEL_W-1:0]    item_dispensed,
  output logic                coin_out_valid,
  output logic [1:0]          coin_out_code,
  output logic [CNT_W-1:0]    change_nickels,
  output logic [CNT_W-1:0]    change_dimes,
  output logic [CNT_W-1:0]    change_quarters,
  output logic [CNT_W-1:0]    change_dollars,
  output logic                change_done,
  output logic                err_funds,
  output logic                err_sold_out,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_VEND = 2'd1, S_CHANGE = 2'd2} state_t;

  // Highest credit that can still absorb a dollar without overflowing.
  localparam logic [CREDIT_W-1:0] CREDIT_LIMIT = CREDIT_W'((2 ** CREDIT_W) - 1 - 100);

  state_t               state;
  logic [CREDIT_W-1:0]  credit_q;
  logic [STOCK_W-1:0]   stock [N_ITEMS];
  logic [SEL_W-1:0]     sel_q;
  logic [CNT_W-1:0]     cnt_n, cnt_d, cnt_q, cnt_l;
  logic                 err_funds_q, err_sold_q;

  logic [CREDIT_W-1:0]  coin_in_val, credit_sum, sel_price, vend_price, out_val;
  logic [1:0]           out_code;
  logic                 sel_bad;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    return CREDIT_W'(5);
      2'd1:    return CREDIT_W'(10);
      2'd2:    return CREDIT_W'(25);
      default: return CREDIT_W'(100);
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    return CREDIT_W'(PRICE_BASE + PRICE_STEP * int'(idx));
  endfunction

  always_comb begin
    coin_in_val = (coin_valid && coin_ready) ? coin_value(coin_code) : '0;
    credit_sum  = credit_q + coin_in_val;
    sel_price   = price_of(selection);
    vend_price  = price_of(sel_q);
    sel_bad     = ({1'b0, selection} >= (SEL_W + 1)'(N_ITEMS)) || (stock[selection] == '0);
    // Greedy choice of the next change coin from the remaining credit.
    if (credit_q >= CREDIT_W'(100))     out_code = 2'd3;
    else if (credit_q >= CREDIT_W'(25)) out_code = 2'd2;
    else if (credit_q >= CREDIT_W'(10)) out_code = 2'd1;
    else                                out_code = 2'd0;
    out_val = coin_value(out_code);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      credit_q    <= '0;
      sel_q       <= '0;
      cnt_n       <= '0;
      cnt_d       <= '0;
      cnt_q       <= '0;
      cnt_l       <= '0;
      err_funds_q <= 1'b0;
      err_sold_q  <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      err_funds_q <= 1'b0;
      err_sold_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          // An accepted coin always lands, whatever else happens this cycle.
          credit_q <= credit_sum;
          if (cancel) begin
            cnt_n <= '0;
            cnt_d <= '0;
            cnt_q <= '0;
            cnt_l <= '0;
            state <= (credit_sum != '0) ? S_CHANGE : S_IDLE;
          end else if (sel_valid) begin
            // Affordability uses credit before this cycle's coin.
            if (sel_bad) begin
              err_sold_q <= 1'b1;
            end else if (credit_q < sel_price) begin
              err_funds_q <= 1'b1;
            end else begin
              sel_q <= selection;
              cnt_n <= '0;
              cnt_d <= '0;
              cnt_q <= '0;
              cnt_l <= '0;
              state <= S_VEND;
            end
          end else if (restock) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
          end
        end
        S_VEND: begin
          stock[sel_q] <= stock[sel_q] - STOCK_W'(1);
          credit_q     <= credit_q - vend_price;
          state        <= (credit_q != vend_price) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          credit_q <= credit_q - out_val;
          case (out_code)
            2'd0:    cnt_n <= cnt_n + CNT_W'(1);
            2'd1:    cnt_d <= cnt_d + CNT_W'(1);
            2'd2:    cnt_q <= cnt_q + CNT_W'(1);
            default: cnt_l <= cnt_l + CNT_W'(1);
          endcase
          if (credit_q == out_val) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
  end

  // Outputs below are decoded from registered state; during a change cycle
  // credit still shows the amount before the coin being emitted.
  assign credit          = credit_q;
  assign coin_ready      = (state == S_IDLE) && (credit_q <= CREDIT_LIMIT);
  assign item_valid      = (state == S_VEND);
  assign item_dispensed  = sel_q;
  assign coin_out_valid  = (state == S_CHANGE);
  assign coin_out_code   = (state == S_CHANGE) ? out_code : 2'd0;
  assign change_done     = (state == S_CHANGE) && (credit_q == out_val);
  assign change_nickels  = cnt_n;
  assign change_dimes    = cnt_d;
  assign change_quarters = cnt_q;
  assign change_dollars  = cnt_l;
  assign err_funds       = err_funds_q;
  assign err_sold_out    = err_sold_q;
  assign busy            = (state != S_IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Testbench for vending_machine_gen: directed scenarios followed by random
// transactions, all checked against a cents-and-counters reference model.
module tb_vending_machine_gen;

  logic       clock = 1'b0;
  logic       reset, coin_valid, sel_valid, cancel, restock;
  logic [1:0] coin_code;
  logic [2:0] selection;
  logic       coin_ready, item_valid, coin_out_valid, change_done;
  logic       err_funds, err_sold_out, busy;
  logic [8:0] credit;
  logic [2:0] item_dispensed;
  logic [1:0] coin_out_code, state_dbg;
  logic [4:0] change_nickels, change_dimes, change_quarters, change_dollars;
  logic [7:0] sold_out;

  vending_machine_gen dut (
    .clock(clock), .reset(reset),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
    .sel_valid(sel_valid), .selection(selection),
    .cancel(cancel), .restock(restock),
    .credit(credit), .item_valid(item_valid), .item_dispensed(item_dispensed),
    .coin_out_valid(coin_out_valid), .coin_out_code(coin_out_code),
    .change_nickels(change_nickels), .change_dimes(change_dimes),
    .change_quarters(change_quarters), .change_dollars(change_dollars),
    .change_done(change_done), .err_funds(err_funds), .err_sold_out(err_sold_out),
    .sold_out(sold_out), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  int vectors = 0;
  int miscompares = 0;
  int m_credit;
  int m_stock [8];
  int m_cnt [4];           // indexed by coin code
  logic [1:0] exp_q [$];   // expected change coins, in order

  function automatic int coin_value(input int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  function automatic int price(input int i);
    return 25 + 15 * i;
  endfunction

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < 8; i++) m_stock[i] = 5;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_checks();
    logic [7:0] so;
    for (int i = 0; i < 8; i++) so[i] = (m_stock[i] == 0);
    chk("busy_idle", busy, 0);
    chk("credit", credit, m_credit);
    chk("coin_ready", coin_ready, (m_credit <= 411));
    chk("sold_out", sold_out, so);
    chk("cnt_nickels", change_nickels, m_cnt[0]);
    chk("cnt_dimes", change_dimes, m_cnt[1]);
    chk("cnt_quarters", change_quarters, m_cnt[2]);
    chk("cnt_dollars", change_dollars, m_cnt[3]);
    chk("coin_out_idle", coin_out_valid, 0);
    chk("item_valid_idle", item_valid, 0);
  endtask

  task automatic clear_inputs();
    coin_valid = 0; coin_code = 0; sel_valid = 0; selection = 0;
    cancel = 0; restock = 0;
  endtask

  // Expects the change sequence for 'total' cents starting in the current
  // cycle; the busy engine is fed random junk that it must ignore.
  task automatic run_change(input int total);
    int r;
    logic [1:0] code;
    r = total;
    for (int k = 0; k < r / 100; k++) exp_q.push_back(2'd3);
    r = r % 100;
    for (int k = 0; k < r / 25; k++) exp_q.push_back(2'd2);
    r = r % 25;
    for (int k = 0; k < r / 10; k++) exp_q.push_back(2'd1);
    r = r % 10;
    for (int k = 0; k < r / 5; k++) exp_q.push_back(2'd0);
    while (exp_q.size() > 0) begin
      code = exp_q.pop_front();
      chk("chg_valid", coin_out_valid, 1);
      chk("chg_code", coin_out_code, code);
      chk("chg_done", change_done, (exp_q.size() == 0));
      chk("chg_busy", busy, 1);
      chk("chg_coin_ready", coin_ready, 0);
      coin_valid = 1'($urandom_range(0, 1));
      coin_code  = 2'($urandom_range(0, 3));
      sel_valid  = 1'($urandom_range(0, 1));
      selection  = 3'($urandom_range(0, 7));
      cancel     = 1'($urandom_range(0, 1));
      restock    = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      m_cnt[code]++;
    end
    m_credit = 0;
    chk("chg_end_done", change_done, 0);
  endtask

  // ---------------- driver ----------------
  // One idle-cycle request, then the whole resulting transaction.
  task automatic step(input bit cv, input int cc, input bit sv, input int sel,
                      input bit can, input bit rk);
    int cval;
    cval = (cv && m_credit <= 411) ? coin_value(cc) : 0;
    coin_valid = cv; coin_code = 2'(cc); sel_valid = sv; selection = 3'(sel);
    cancel = can; restock = rk;
    tick();
    clear_inputs();
    if (can) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_credit = m_credit + cval;
      chk("cancel_item", item_valid, 0);
      if (m_credit > 0) run_change(m_credit);
    end else if (sv) begin
      if (sel >= 8 || m_stock[sel] == 0) begin
        chk("err_sold_out", err_sold_out, 1);
        chk("err_funds_quiet", err_funds, 0);
        chk("rej_item", item_valid, 0);
        m_credit = m_credit + cval;
      end else if (m_credit < price(sel)) begin
        chk("err_funds", err_funds, 1);
        chk("err_sold_quiet", err_sold_out, 0);
        chk("rej_item", item_valid, 0);
        m_credit = m_credit + cval;
      end else begin
        chk("vend_valid", item_valid, 1);
        chk("vend_item", item_dispensed, sel);
        chk("vend_busy", busy, 1);
        chk("vend_errs", {err_funds, err_sold_out}, 0);
        chk("vend_no_coin", coin_out_valid, 0);
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_credit = m_credit + cval - price(sel);
        m_stock[sel]--;
        tick();
        if (m_credit > 0) run_change(m_credit);
        else chk("exact_no_done", change_done, 0);
      end
    end else begin
      if (rk) for (int i = 0; i < 8; i++) m_stock[i] = 5;
      m_credit = m_credit + cval;
      chk("quiet_errs", {err_funds, err_sold_out}, 0);
    end
    idle_checks();
  endtask

  // ---------------- sequence ----------------
  initial begin
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_reset();

    // Reset state.
    chk("rst_errs", {err_funds, err_sold_out, change_done}, 0);
    idle_checks();

    // 60 cents is short of item 3 (70); one more dime buys it exactly.
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);

    // 125 cents for item 2 (55): change Q, Q, D, D.
    step(1, 3, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    chk("plan_quarters", change_quarters, 2);
    chk("plan_dimes", change_dimes, 2);

    // Empty slot 0, reject the sixth purchase, then restock.
    for (int n = 0; n < 5; n++) begin
      step(1, 2, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
    end
    chk("slot0_empty", sold_out[0], 1);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // Credit 40, then cancel with a nickel in the same cycle: 45 back.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);

    // Five dollars saturates coin acceptance; item 7 leaves 370 in change.
    for (int n = 0; n < 6; n++) step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    chk("big_dollars", change_dollars, 3);

    // Same purchase again, with reset during the second change coin.
    for (int n = 0; n < 5; n++) step(1, 3, 0, 0, 0, 0);
    sel_valid = 1; selection = 3'd7;
    tick();
    clear_inputs();
    chk("mid_vend", item_valid, 1);
    tick();
    chk("mid_coin1", coin_out_code, 3);
    tick();
    chk("mid_coin2_valid", coin_out_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    chk("mid_rst_state", state_dbg, 0);
    idle_checks();

    // Random transactions.
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3), (r < 5),
           $urandom_range(0, 7), ($urandom_range(0, 7) == 0), (r == 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
